mul_seq: RTL and testbench

Multi-cycle 32×32→64 multiplier controller that reaches its result by sequencing the existing 32-bit combinational `alu` as its only arithmetic resource. It uses shift-and-add over 32 iterations, plus optional two's-complement fix-up passes. It sits beside the CPU31 execute stage, and the stage holds on `busy`. Start is a single-cycle request, and completion is a one-cycle `done` pulse with registered `{hi, lo}`.

---
 rtl/mul_seq_pkg.sv | 27 ++
 rtl/alu.sv | 54 +++++
 rtl/mul_seq.sv | 213 +++++++++++++++++++++
 tb/tb_mul_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential multiplier and its ALU.
// The signed datapath is compiled in only when MUL_SEQ_SIGNED_EN is defined.
package mul_seq_pkg;

  localparam int MUL_ITERS = 32;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABS_A   = 3'd1,
    ST_ABS_B   = 3'd2,
    ST_ITER    = 3'd3,
    ST_NEG_LO  = 3'd4,
    ST_NEG_HI  = 3'd5,
    ST_NEG_HI2 = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

endpackage

// File: rtl/alu.sv
// CPU31 32-bit combinational ALU. For the unsigned add/sub codes, carry is
// the carry-out on add and the borrow (a < b) on subtract.
module alu
  import mul_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        carry,
  output logic        overflow,
  output logic        negative,
  output logic        zero
);

  logic [32:0] sum_ext;
  logic [32:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (aluc)
      ALUC_ADDU: begin
        r     = sum_ext[31:0];
        carry = sum_ext[32];
      end
      ALUC_SUBU: begin
        r     = diff_ext[31:0];
        carry = diff_ext[32];
      end
      ALUC_ADD: begin
        r        = sum_ext[31:0];
        overflow = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALUC_SUB: begin
        r        = diff_ext[31:0];
        overflow = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALUC_AND: r = a & b;
      ALUC_OR:  r = a | b;
      ALUC_XOR: r = a ^ b;
      ALUC_NOR: r = ~(a | b);
      default:  r = '0;
    endcase
  end

  assign negative = r[31];
  assign zero     = (r == 32'd0);

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle 32x32->64 shift-and-add multiplier sequencing the shared alu.
// Define MUL_SEQ_SIGNED_EN to honour `sign` (abs / negate fix-up passes).
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MUL_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;
  logic             last_iter;

  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_c;
  logic        alu_carry, alu_ovf, alu_neg, alu_zero;
  logic        unused_alu_flags;

`ifdef MUL_SEQ_SIGNED_EN
  logic neg_q, neg_d;
  logic sgn_q, sgn_d;
  logic lo_nz_q, lo_nz_d;
`else
  logic unused_sign;
  assign unused_sign = sign;
`endif

  assign unused_alu_flags = ^{alu_ovf, alu_neg, alu_zero};

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .aluc     (alu_c),
    .r        (alu_r),
    .carry    (alu_carry),
    .overflow (alu_ovf),
    .negative (alu_neg),
    .zero     (alu_zero)
  );

  // DONE doubles as an accept slot so back-to-back requests lose no cycle.
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_iter = (cnt_q == 6'(ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
`ifdef MUL_SEQ_SIGNED_EN
          state_d = sign ? ST_ABS_A : ST_ITER;
`else
          state_d = ST_ITER;
`endif
        end
      end
`ifdef MUL_SEQ_SIGNED_EN
      ST_ABS_A:   state_d = ST_ABS_B;
      ST_ABS_B:   state_d = ST_ITER;
      ST_NEG_LO:  state_d = ST_NEG_HI;
      ST_NEG_HI:  state_d = ST_NEG_HI2;
      ST_NEG_HI2: state_d = ST_DONE;
`endif
      ST_ITER: begin
        if (last_iter) begin
`ifdef MUL_SEQ_SIGNED_EN
          state_d = sgn_q ? ST_NEG_LO : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_c   = ALUC_ADDU;
`ifdef MUL_SEQ_SIGNED_EN
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    lo_nz_d = lo_nz_q;
`endif

    case (state_q)
      ST_ITER: begin
        alu_a = acc_q;
        alu_b = mcand_q;
        // The right shift of {acc, mplr} is pure wiring around the adder.
        {acc_d, mplr_d} = mplr_q[0] ? {alu_carry, alu_r, mplr_q[WIDTH-1:1]}
                                    : {1'b0, acc_q, mplr_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
      end
`ifdef MUL_SEQ_SIGNED_EN
      ST_ABS_A: begin
        alu_b = mcand_q;
        alu_c = ALUC_SUBU;
        if (sgn_q && mcand_q[WIDTH-1]) mcand_d = alu_r;
      end
      ST_ABS_B: begin
        alu_b = mplr_q;
        alu_c = ALUC_SUBU;
        if (sgn_q && mplr_q[WIDTH-1]) mplr_d = alu_r;
      end
      ST_NEG_LO: begin
        alu_b   = mplr_q;
        alu_c   = ALUC_SUBU;
        lo_nz_d = alu_carry;
        if (neg_q) mplr_d = alu_r;
      end
      ST_NEG_HI: begin
        alu_b = acc_q;
        alu_c = ALUC_SUBU;
        if (neg_q) acc_d = alu_r;
      end
      ST_NEG_HI2: begin
        // Borrow out of the low-half negate propagates into the high half.
        alu_a = acc_q;
        alu_b = 32'd1;
        alu_c = ALUC_SUBU;
        if (neg_q && lo_nz_q) acc_d = alu_r;
      end
`endif
      default: ;
    endcase

    if (state_q == ST_DONE) begin
      hi_d   = acc_q;
      lo_d   = mplr_q;
      done_d = 1'b1;
    end

    if (accept) begin
      mcand_d = a;
      mplr_d  = b;
      acc_d   = '0;
      cnt_d   = '0;
`ifdef MUL_SEQ_SIGNED_EN
      neg_d   = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      sgn_d   = sign;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      lo_nz_q <= 1'b0;
`endif
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MUL_SEQ_SIGNED_EN
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      lo_nz_q <= lo_nz_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: reference products from 64-bit arithmetic, latency from
// the documented cycle counts; follows MUL_SEQ_SIGNED_EN like the design.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

`ifdef MUL_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  mul_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // reference model
  function automatic logic [63:0] model_product(input logic [31:0] x, input logic [31:0] y,
                                                input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {32'd0, x};
    ye = {32'd0, y};
    if (SIGNED_EN && s) begin
      xe = {{32{x[31]}}, x};
      ye = {{32{y[31]}}, y};
    end
    return xe * ye;
  endfunction

  function automatic int model_latency(input logic s);
    return (SIGNED_EN && s) ? 38 : 33;
  endfunction

  // driver: issue one request, optionally poke start while busy, wait for done
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int poke_at, output logic [31:0] h, output logic [31:0] l,
                        output int lat);
    a = x; b = y; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
    lat = -1; h = hi; l = lo;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; h = hi; l = lo;
        break;
      end
      if (n == poke_at) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max();
    logic [31:0] h, l;
    logic [63:0] e;
    int lat;
    exp_q.push_back(model_product(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, h, l, lat);
    e = exp_q.pop_front();
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL umax_hi: got %h want %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL umax_lo: got %h want %h", l, e[31:0]); end
    checks++; if (lat != 33) begin errors++; $display("FAIL umax_latency: got %0d want 33", lat); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL umax_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_signed_table();
    logic [31:0] xs[4];
    logic [31:0] ys[4];
    logic [31:0] h, l;
    logic [63:0] e;
    int lat;
    xs[0] = 32'hFFFFFFFD; ys[0] = 32'd7;
    xs[1] = 32'h80000000; ys[1] = 32'h80000000;
    xs[2] = 32'hFFFFFFFF; ys[2] = 32'd0;
    xs[3] = 32'hFFFFFFFF; ys[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_product(xs[i], ys[i], 1'b1));
      run_op(xs[i], ys[i], 1'b1, 0, h, l, lat);
      e = exp_q.pop_front();
      checks++; if (h !== e[63:32]) begin errors++; $display("FAIL signed%0d_hi: got %h want %h", i, h, e[63:32]); end
      checks++; if (l !== e[31:0]) begin errors++; $display("FAIL signed%0d_lo: got %h want %h", i, l, e[31:0]); end
      checks++; if (lat != model_latency(1'b1)) begin errors++; $display("FAIL signed%0d_latency: got %0d want %0d", i, lat, model_latency(1'b1)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, h, l;
    logic s;
    logic [63:0] e;
    int lat;
    for (int i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) x = 32'h80000000;
      if ($urandom_range(0, 3) == 0) y = 32'hFFFFFFFF;
      exp_q.push_back(model_product(x, y, s));
      run_op(x, y, s, 0, h, l, lat);
      e = exp_q.pop_front();
      checks++; if (h !== e[63:32]) begin errors++; $display("FAIL rand%0d_hi: %h*%h s=%b got %h want %h", i, x, y, s, h, e[63:32]); end
      checks++; if (l !== e[31:0]) begin errors++; $display("FAIL rand%0d_lo: %h*%h s=%b got %h want %h", i, x, y, s, l, e[31:0]); end
      checks++; if (lat != model_latency(s)) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, model_latency(s)); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL rand%0d_hold: got %h want %h", i, {hi, lo}, e); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] x, y, h, l;
    logic [63:0] e;
    int lat;
    int extra;
    x = $urandom; y = $urandom;
    exp_q.push_back(model_product(x, y, 1'b0));
    run_op(x, y, 1'b0, 5, h, l, lat);
    e = exp_q.pop_front();
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL ignore_hi: got %h want %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL ignore_lo: got %h want %h", l, e[31:0]); end
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    extra = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_not_queued: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2;
    logic [63:0] e1, e2;
    int waited, lat2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom | 32'h1;
    exp_q.push_back(model_product(x1, y1, 1'b0));
    exp_q.push_back(model_product(x2, y2, 1'b0));
    a = x1; b = y1; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (!busy) begin waited = n; break; end
    end
    checks++; if (waited != 32) begin errors++; $display("FAIL b2b_busy_fall: got %0d want 32", waited); end
    a = x2; b = y2; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e1 = exp_q.pop_front();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
    checks++; if ({hi, lo} !== e1) begin errors++; $display("FAIL b2b_first_result: got %h want %h", {hi, lo}, e1); end
    lat2 = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = n; break; end
    end
    e2 = exp_q.pop_front();
    checks++; if (lat2 != 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", lat2); end
    checks++; if ({hi, lo} !== e2) begin errors++; $display("FAIL b2b_second_result: got %h want %h", {hi, lo}, e2); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] x, y, h, l;
    logic s;
    logic [63:0] e;
    int lat;
    int extra;
    a = $urandom; b = $urandom | 32'h1; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h want 0", lo); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", extra); end
    x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
    exp_q.push_back(model_product(x, y, s));
    run_op(x, y, s, 0, h, l, lat);
    e = exp_q.pop_front();
    checks++; if ({h, l} !== e) begin errors++; $display("FAIL abort_restart_result: got %h want %h", {h, l}, e); end
    checks++; if (lat != model_latency(s)) begin errors++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, model_latency(s)); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_table();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
